// File: rtl/line_loader.sv
// Byte-stream to 12-bit pixel unpacker feeding a ping-pong line memory.
// Every 3 accepted bytes become two pixels. A full write bank is handed to the display on line_swap.
module line_loader #(
  parameter int NATIVE_HRES = 800,
  parameter int NATIVE_VRES = 600,
  parameter int BITPERPIXEL = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  input  logic                   in_sof,
  output logic                   in_ready,
  output logic                   wr_en,
  output logic                   wr_bank,
  output logic [10:0]            wr_addr,
  output logic [BITPERPIXEL-1:0] wr_data,
  input  logic                   line_swap,
  output logic                   rd_bank,
  output logic [10:0]            line_num,
  output logic                   line_valid,
  output logic                   frame_done,
  output logic                   underrun,
  output logic                   resync
);

  localparam logic [10:0] LAST_PIX  = 11'(NATIVE_HRES - 1);
  localparam logic [10:0] LAST_LINE = 11'(NATIVE_VRES - 1);

  typedef enum logic [2:0] {
    WAIT_SOF = 3'd0,
    PH0      = 3'd1,
    PH1      = 3'd2,
    PH2      = 3'd3,
    FULL     = 3'd4
  } state_t;

  state_t      state;
  logic [7:0]  b0_p0;
  logic [7:0]  b1_p0;
  logic [10:0] pix_cnt;
  logic [10:0] line_cnt;
  logic [10:0] wr_line;
  logic        accept;

  assign accept = in_valid && in_ready;

  // Pixel packing: b0 b1 b2 -> {b0, b1[7:4]}, {b1[3:0], b2}
  function automatic logic [BITPERPIXEL-1:0] pix_even(input logic [7:0] b0, input logic [7:0] b1);
    return {b0, b1[7:4]};
  endfunction

  function automatic logic [BITPERPIXEL-1:0] pix_odd(input logic [7:0] b1, input logic [7:0] b2);
    return {b1[3:0], b2};
  endfunction

  function automatic logic [10:0] next_line(input logic [10:0] cur);
    return (cur == LAST_LINE) ? 11'd0 : 11'(cur + 11'd1);
  endfunction

  // Byte holding registers: pure data, no reset needed
  always_ff @(posedge clk) begin
    if (accept) begin
      if (in_sof || state == WAIT_SOF || state == PH0)
        b0_p0 <= in_data;
      else if (state == PH1)
        b1_p0 <= in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= WAIT_SOF;
      in_ready   <= 1'b0;
      pix_cnt    <= 11'd0;
      line_cnt   <= 11'd0;
      wr_line    <= 11'd0;
      wr_en      <= 1'b0;
      wr_bank    <= 1'b1;
      wr_addr    <= 11'd0;
      wr_data    <= '0;
      rd_bank    <= 1'b0;
      line_num   <= 11'd0;
      line_valid <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      resync     <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      resync     <= 1'b0;
      in_ready   <= (state != FULL);

      if (line_swap) begin
        if (state == FULL) begin
          rd_bank    <= ~rd_bank;
          wr_bank    <= rd_bank;
          line_num   <= wr_line;
          line_valid <= 1'b1;
          state      <= PH0;
          in_ready   <= 1'b1;
        end else begin
          underrun <= 1'b1;
        end
      end

      // in_ready is low in FULL, so no byte is ever accepted there
      if (accept) begin
        if (state == WAIT_SOF) begin
          if (in_sof) begin
            pix_cnt  <= 11'd0;
            line_cnt <= 11'd0;
            state    <= PH1;
          end
        end else if (in_sof) begin
          // Start of frame restarts line 0; only a real restart is flagged
          if (state != PH0 || pix_cnt != 11'd0 || line_cnt != 11'd0)
            resync <= 1'b1;
          pix_cnt  <= 11'd0;
          line_cnt <= 11'd0;
          state    <= PH1;
        end else begin
          case (state)
            PH0: state <= PH1;
            PH1: begin
              wr_en   <= 1'b1;
              wr_addr <= pix_cnt;
              wr_data <= pix_even(b0_p0, in_data);
              pix_cnt <= 11'(pix_cnt + 11'd1);
              state   <= PH2;
            end
            PH2: begin
              wr_en   <= 1'b1;
              wr_addr <= pix_cnt;
              wr_data <= pix_odd(b1_p0, in_data);
              if (pix_cnt == LAST_PIX) begin
                pix_cnt    <= 11'd0;
                wr_line    <= line_cnt;
                line_cnt   <= next_line(line_cnt);
                frame_done <= (line_cnt == LAST_LINE);
                in_ready   <= 1'b0;
                state      <= FULL;
              end else begin
                pix_cnt <= 11'(pix_cnt + 11'd1);
                state   <= PH0;
              end
            end
            default: state <= state;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_line_loader.sv
// Directed bench for line_loader: unpacking, handoff, underrun, resync, frame wrap and mid-line reset.
module tb_line_loader;

  localparam int H = 800;
  localparam int V = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_sof;
  logic        in_ready;
  logic        wr_en;
  logic        wr_bank;
  logic [10:0] wr_addr;
  logic [11:0] wr_data;
  logic        line_swap;
  logic        rd_bank;
  logic [10:0] line_num;
  logic        line_valid;
  logic        frame_done;
  logic        underrun;
  logic        resync;

  int n_chk = 0;
  int n_pass = 0;
  int n_wr = 0;
  int n_und = 0;
  int n_rsy = 0;
  int n_fd = 0;
  int wr_mark;

  always #5 clk = ~clk;

  line_loader #(
    .NATIVE_HRES(H),
    .NATIVE_VRES(V),
    .BITPERPIXEL(12)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_sof(in_sof),
    .in_ready(in_ready),
    .wr_en(wr_en),
    .wr_bank(wr_bank),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .line_swap(line_swap),
    .rd_bank(rd_bank),
    .line_num(line_num),
    .line_valid(line_valid),
    .frame_done(frame_done),
    .underrun(underrun),
    .resync(resync)
  );

  always @(negedge clk) begin
    if (wr_en)      n_wr  <= n_wr + 1;
    if (underrun)   n_und <= n_und + 1;
    if (resync)     n_rsy <= n_rsy + 1;
    if (frame_done) n_fd  <= n_fd + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic logic [7:0] pat(input int l, input int k);
    return 8'(18 + 34 * k + 5 * l);
  endfunction

  function automatic logic [11:0] exp_pix(input int l, input int p);
    logic [7:0] b0, b1, b2;
    int k;
    k  = 3 * (p / 2);
    b0 = pat(l, k);
    b1 = pat(l, k + 1);
    b2 = pat(l, k + 2);
    return (p % 2 == 0) ? {b0, b1[7:4]} : {b1[3:0], b2};
  endfunction

  task automatic send(input logic [7:0] b, input logic sof, input logic sw);
    int n;
    in_data  = b;
    in_sof   = sof;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("rdy_timeout", 32'(in_ready), 32'd1);
    else begin
      line_swap = sw;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    line_swap = 1'b0;
  endtask

  task automatic send_range(input int l, input int k0, input int k1);
    for (int k = k0; k <= k1; k++) send(pat(l, k), 1'b0, 1'b0);
  endtask

  task automatic swap();
    line_swap = 1'b1;
    @(posedge clk); #1;
    line_swap = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_data = 8'h00; in_valid = 1'b0; in_sof = 1'b0; line_swap = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_rd_bank", 32'(rd_bank), 32'd0);
    chk("rst_wr_bank", 32'(wr_bank), 32'd1);
    chk("rst_line_valid", 32'(line_valid), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    reset = 1'b0;
    chk("rdy_before_edge", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("rdy_after_edge", 32'(in_ready), 32'd1);

    // bytes before any sof are dropped
    for (int i = 0; i < 3; i++) send(8'hAA, 1'b0, 1'b0);
    settle();
    chk("drop_nwr", 32'(n_wr), 32'd0);

    // first pixels of line 0
    send(8'h12, 1'b1, 1'b0);
    chk("b0_no_wr", 32'(wr_en), 32'd0);
    send(8'h34, 1'b0, 1'b0);
    chk("p0_wr_en", 32'(wr_en), 32'd1);
    chk("p0_addr", 32'(wr_addr), 32'd0);
    chk("p0_data", 32'(wr_data), 32'h123);
    chk("p0_bank", 32'(wr_bank), 32'd1);
    send(8'h56, 1'b0, 1'b0);
    chk("p1_wr_en", 32'(wr_en), 32'd1);
    chk("p1_addr", 32'(wr_addr), 32'd1);
    chk("p1_data", 32'(wr_data), 32'h456);

    // rest of line 0 then handoff
    send_range(0, 3, 1199);
    chk("l0_last_addr", 32'(wr_addr), 32'd799);
    chk("l0_last_data", 32'(wr_data), 32'hE50);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_lv", 32'(line_valid), 32'd0);
    settle();
    chk("l0_nwr", 32'(n_wr), 32'd800);
    swap();
    chk("sw0_rd_bank", 32'(rd_bank), 32'd1);
    chk("sw0_line_num", 32'(line_num), 32'd0);
    chk("sw0_lv", 32'(line_valid), 32'd1);
    chk("sw0_in_ready", 32'(in_ready), 32'd1);
    chk("sw0_no_under", 32'(underrun), 32'd0);
    send(pat(1, 0), 1'b0, 1'b0);
    send(pat(1, 1), 1'b0, 1'b0);
    chk("l1_bank", 32'(wr_bank), 32'd0);
    chk("l1_addr", 32'(wr_addr), 32'd0);
    chk("l1_data", 32'(wr_data), 32'(exp_pix(1, 0)));

    // underrun: swap in PH1 and on the final handshake
    send(pat(1, 2), 1'b0, 1'b0);
    send(pat(1, 3), 1'b0, 1'b0);
    swap();
    chk("ur_ph1_pulse", 32'(underrun), 32'd1);
    chk("ur_ph1_rd_bank", 32'(rd_bank), 32'd1);
    chk("ur_ph1_line_num", 32'(line_num), 32'd0);
    send_range(1, 4, 1198);
    send(pat(1, 1199), 1'b0, 1'b1);
    chk("ur_last_pulse", 32'(underrun), 32'd1);
    chk("ur_last_in_ready", 32'(in_ready), 32'd0);
    chk("ur_last_rd_bank", 32'(rd_bank), 32'd1);
    chk("l1_last_data", 32'(wr_data), 32'(exp_pix(1, 799)));
    swap();
    chk("sw1_rd_bank", 32'(rd_bank), 32'd0);
    chk("sw1_line_num", 32'(line_num), 32'd1);
    chk("sw1_no_under", 32'(underrun), 32'd0);
    settle();
    chk("ur_count", 32'(n_und), 32'd2);
    chk("l1_nwr", 32'(n_wr), 32'd1600);

    // resync at byte 600 of line 3
    send_range(2, 0, 1199);
    swap();
    chk("sw2_line_num", 32'(line_num), 32'd2);
    send_range(3, 0, 599);
    send(pat(0, 0), 1'b1, 1'b0);
    chk("rs_pulse", 32'(resync), 32'd1);
    chk("rs_rd_bank", 32'(rd_bank), 32'd1);
    chk("rs_lv", 32'(line_valid), 32'd1);
    send(pat(0, 1), 1'b0, 1'b0);
    chk("rs_one_cycle", 32'(resync), 32'd0);
    chk("rs_addr", 32'(wr_addr), 32'd0);
    chk("rs_bank", 32'(wr_bank), 32'd0);
    chk("rs_data", 32'(wr_data), 32'h123);
    send_range(0, 2, 1199);
    swap();
    chk("rs_line_num", 32'(line_num), 32'd0);
    chk("rs_sw_rd_bank", 32'(rd_bank), 32'd0);
    settle();
    chk("rs_count", 32'(n_rsy), 32'd1);
    chk("rs_nwr", 32'(n_wr), 32'd3600);

    // rest of the frame, then wrap
    for (int l = 1; l < V; l++) begin
      send_range(l, 0, 1199);
      if (l == V - 2) chk("fd_early", 32'(frame_done), 32'd0);
      if (l == V - 1) chk("fd_pulse", 32'(frame_done), 32'd1);
      swap();
      chk("frame_line_num", 32'(line_num), 32'(l));
    end
    settle();
    chk("fd_count", 32'(n_fd), 32'd1);
    send_range(0, 0, 1199);
    chk("wrap_no_fd", 32'(frame_done), 32'd0);
    swap();
    chk("wrap_line_num", 32'(line_num), 32'd0);

    // reset in PH2 mid-line
    send(pat(1, 0), 1'b0, 1'b0);
    send(pat(1, 1), 1'b0, 1'b0);
    chk("pre_rst_wr_en", 32'(wr_en), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
    chk("mid_rst_rd_bank", 32'(rd_bank), 32'd0);
    chk("mid_rst_wr_bank", 32'(wr_bank), 32'd1);
    chk("mid_rst_lv", 32'(line_valid), 32'd0);
    chk("mid_rst_line_num", 32'(line_num), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    settle();
    wr_mark = n_wr;
    for (int i = 0; i < 3; i++) send(8'h5A, 1'b0, 1'b0);
    settle();
    chk("post_rst_drop", 32'(n_wr), 32'(wr_mark));
    send(pat(0, 0), 1'b1, 1'b0);
    send(pat(0, 1), 1'b0, 1'b0);
    chk("post_rst_addr", 32'(wr_addr), 32'd0);
    chk("post_rst_bank", 32'(wr_bank), 32'd1);
    chk("post_rst_data", 32'(wr_data), 32'h123);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
